// File: rtl/run_pkg.sv
// run_pkg: shared types for the run monitor.
//   state_t  - FSM state encoding exposed on run_monitor.state
//   status_t - end-of-run cause exposed on run_monitor.status
//   is_terminal() - true for HALTED, TIMEOUT and ERROR
package run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_HALTED  = 3'd2,
        ST_TIMEOUT = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STS_NONE    = 2'b00,
        STS_HALT    = 2'b01,
        STS_TIMEOUT = 2'b10,
        STS_ERROR   = 2'b11
    } status_t;

    function automatic logic is_terminal(input state_t s);
        return (s == ST_HALTED) || (s == ST_TIMEOUT) || (s == ST_ERROR);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all ones instead of wrapping.
//   clk - clock
//   rst - synchronous active-low reset
//   clr - synchronous clear (wins over inc)
//   inc - count one when not saturated
//   q   - count value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/run_monitor.sv
// run_monitor: tracks one run of NUM_CH channels, counting retired
// instructions per channel and RUN cycles, and records why the run ended
// (all channels halted, timeout or fatal error).
//   clk         - clock
//   rst         - synchronous active-low reset
//   start       - begin a run (IDLE only; wins over clear)
//   clear       - abort a run / acknowledge a finished one
//   retire_p1   - per-channel instruction-retired strobe
//   halt_p1     - per-channel halt strobe
//   err_p1      - shared fatal error strobe
//   inst_count  - packed per-channel retired counts, channel 0 in LSBs
//   cycle_count - cycles spent in RUN
//   halted_mask - channels halted in the current run
//   state       - FSM state (run_pkg::state_t)
//   status      - end cause (run_pkg::status_t)
//   done        - high in HALTED, TIMEOUT and ERROR
//
// state   | meaning
// IDLE    | waiting for start; last run's results stay readable
// RUN     | counting cycles and retires
// HALTED  | every channel halted (terminal)
// TIMEOUT | TIMEOUT cycles elapsed in RUN (terminal)
// ERROR   | err_p1 seen in RUN (terminal)
module run_monitor
    import run_pkg::*;
#(
    parameter int NUM_CH  = 1,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 10000,
    localparam int CYC_W  = $clog2(TIMEOUT + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clear,
    input  logic [NUM_CH-1:0]       retire_p1,
    input  logic [NUM_CH-1:0]       halt_p1,
    input  logic                    err_p1,
    output logic [NUM_CH*CNT_W-1:0] inst_count,
    output logic [CYC_W-1:0]        cycle_count,
    output logic [NUM_CH-1:0]       halted_mask,
    output logic [2:0]              state,
    output logic [1:0]              status,
    output logic                    done
);

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    status_t           status_q, status_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic              done_q;
    logic              cnt_clr;
    logic              cnt_run;
    logic [NUM_CH-1:0] cnt_inc;
    logic              all_halted;

    // A halt arriving this cycle counts toward "all halted" immediately.
    assign all_halted = &(mask_q | halt_p1);

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        cyc_d    = cyc_q;
        mask_d   = mask_q;
        cnt_clr  = 1'b0;
        cnt_run  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    status_d = STS_NONE;
                    cyc_d    = '0;
                    mask_d   = '0;
                    cnt_clr  = 1'b1;
                end
            end
            ST_RUN: begin
                if (clear) begin
                    // Abort: results are frozen as they stand.
                    state_d  = ST_IDLE;
                    status_d = STS_NONE;
                end else begin
                    // Exit edges still account for this cycle's activity.
                    cnt_run = 1'b1;
                    cyc_d   = cyc_q + CYC_W'(1);
                    mask_d  = mask_q | halt_p1;
                    if (err_p1) begin
                        state_d  = ST_ERROR;
                        status_d = STS_ERROR;
                    end else if (all_halted) begin
                        state_d  = ST_HALTED;
                        status_d = STS_HALT;
                    end else if (cyc_q == CYC_LAST) begin
                        state_d  = ST_TIMEOUT;
                        status_d = STS_TIMEOUT;
                    end
                end
            end
            ST_HALTED, ST_TIMEOUT, ST_ERROR: begin
                if (clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                status_d = STS_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            status_q <= STS_NONE;
            cyc_q    <= '0;
            mask_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cyc_q    <= cyc_d;
            mask_q   <= mask_d;
            done_q   <= is_terminal(state_d);
        end
    end

    // Old mask: a retire in the same cycle as its channel's halt still counts.
    assign cnt_inc = cnt_run ? (retire_p1 & ~mask_q) : '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (cnt_clr),
            .inc (cnt_inc[g]),
            .q   (inst_count[g*CNT_W +: CNT_W])
        );
    end

    assign cycle_count = cyc_q;
    assign halted_mask = mask_q;
    assign state       = state_q;
    assign status      = status_q;
    assign done        = done_q;

endmodule

// File: tb/tb_run_monitor.sv
module tb_run_monitor;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 20;
    localparam int CYC_W   = $clog2(TIMEOUT + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    clear;
    logic [NUM_CH-1:0]       retire_p1;
    logic [NUM_CH-1:0]       halt_p1;
    logic                    err_p1;
    logic [NUM_CH*CNT_W-1:0] inst_count;
    logic [CYC_W-1:0]        cycle_count;
    logic [NUM_CH-1:0]       halted_mask;
    logic [2:0]              state;
    logic [1:0]              status;
    logic                    done;

    int n_cmp  = 0;
    int n_fail = 0;

    run_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .clear       (clear),
        .retire_p1   (retire_p1),
        .halt_p1     (halt_p1),
        .err_p1      (err_p1),
        .inst_count  (inst_count),
        .cycle_count (cycle_count),
        .halted_mask (halted_mask),
        .state       (state),
        .status      (status),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 0; clear = 0; retire_p1 = '0; halt_p1 = '0; err_p1 = 0;
    endtask

    task automatic test_reset();
        rst = 0; quiet(); start = 1;
        tick(); tick();
        n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
        n_cmp++; if ({inst_count, cycle_count, halted_mask, status, done} !== '0) begin
            n_fail++; $display("FAIL reset_outputs inst=%h cyc=%0d mask=%b sts=%b done=%b exp all 0",
                               inst_count, cycle_count, halted_mask, status, done); end
        rst = 1;
        tick();   // start held high: honoured on first edge with rst=1
        n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL reset_first_start got=%0d exp=1", state); end
        quiet(); clear = 1; tick(); quiet();
    endtask

    task automatic test_halt();
        start = 1; tick(); start = 0;
        retire_p1 = '1;
        repeat (5) tick();
        n_cmp++; if (inst_count !== {3'd5, 3'd5} || done !== 1'b0) begin
            n_fail++; $display("FAIL halt_pre inst=%h done=%b exp=2d/0", inst_count, done); end
        halt_p1 = '1;
        tick(); quiet();
        n_cmp++; if (state !== 3'd2 || status !== 2'b01 || done !== 1'b1) begin
            n_fail++; $display("FAIL halt_end state=%0d sts=%b done=%b exp=2/01/1", state, status, done); end
        n_cmp++; if (inst_count !== {3'd6, 3'd6}) begin
            n_fail++; $display("FAIL halt_count got=%h exp=%h", inst_count, {3'd6, 3'd6}); end
        clear = 1; tick(); quiet();
        n_cmp++; if (state !== 3'd0 || status !== 2'b01 || done !== 1'b0) begin
            n_fail++; $display("FAIL halt_ack state=%0d sts=%b done=%b exp=0/01/0", state, status, done); end
    endtask

    task automatic test_timeout();
        start = 1; tick(); start = 0;
        repeat (TIMEOUT - 1) tick();
        n_cmp++; if (state !== 3'd1 || cycle_count !== CYC_W'(TIMEOUT - 1)) begin
            n_fail++; $display("FAIL timeout_pre state=%0d cyc=%0d exp=1/%0d", state, cycle_count, TIMEOUT - 1); end
        tick();
        n_cmp++; if (state !== 3'd3 || status !== 2'b10 || cycle_count !== CYC_W'(TIMEOUT)) begin
            n_fail++; $display("FAIL timeout_end state=%0d sts=%b cyc=%0d exp=3/10/%0d", state, status, cycle_count, TIMEOUT); end
        start = 1; retire_p1 = '1; halt_p1 = '1; err_p1 = 1;
        tick(); quiet();
        n_cmp++; if (state !== 3'd3 || inst_count !== '0 || halted_mask !== '0 || status !== 2'b10) begin
            n_fail++; $display("FAIL timeout_frozen state=%0d inst=%h mask=%b sts=%b", state, inst_count, halted_mask, status); end
        clear = 1; tick(); quiet();
        n_cmp++; if (state !== 3'd0 || status !== 2'b10 || cycle_count !== CYC_W'(TIMEOUT)) begin
            n_fail++; $display("FAIL timeout_ack state=%0d sts=%b cyc=%0d", state, status, cycle_count); end
    endtask

    task automatic test_partial_halt();
        start = 1; tick(); start = 0;
        for (int c = 1; c <= 7; c++) begin
            retire_p1 = 2'b01;
            halt_p1   = {c == 7, c == 3};
            tick();
            if (c == 3) begin
                n_cmp++; if (halted_mask !== 2'b01) begin n_fail++; $display("FAIL partial_mask got=%b exp=01", halted_mask); end
            end
            if (c == 6) begin
                n_cmp++; if (state !== 3'd1) begin n_fail++; $display("FAIL partial_run got=%0d exp=1", state); end
            end
        end
        quiet();
        n_cmp++; if (state !== 3'd2 || halted_mask !== 2'b11 || cycle_count !== CYC_W'(7)) begin
            n_fail++; $display("FAIL partial_end state=%0d mask=%b cyc=%0d exp=2/11/7", state, halted_mask, cycle_count); end
        n_cmp++; if (inst_count !== {3'd0, 3'd3}) begin
            n_fail++; $display("FAIL partial_count got=%h exp=%h", inst_count, {3'd0, 3'd3}); end
        clear = 1; tick(); quiet();
    endtask

    task automatic test_saturate();
        start = 1; tick(); start = 0;
        retire_p1 = 2'b01;
        repeat (10) tick();
        quiet();
        n_cmp++; if (inst_count !== {3'd0, 3'd7} || state !== 3'd1) begin
            n_fail++; $display("FAIL saturate got=%h state=%0d exp=%h/1", inst_count, state, {3'd0, 3'd7}); end
        clear = 1; retire_p1 = '1; tick(); quiet();
        n_cmp++; if (state !== 3'd0 || status !== 2'b00 || inst_count !== {3'd0, 3'd7} || cycle_count !== CYC_W'(10)) begin
            n_fail++; $display("FAIL abort_hold state=%0d sts=%b inst=%h cyc=%0d", state, status, inst_count, cycle_count); end
    endtask

    task automatic test_simultaneous();
        start = 1; clear = 1; tick(); quiet();
        n_cmp++; if (state !== 3'd1 || inst_count !== '0 || cycle_count !== '0) begin
            n_fail++; $display("FAIL start_wins state=%0d inst=%h cyc=%0d exp=1/0/0", state, inst_count, cycle_count); end
        repeat (TIMEOUT - 1) tick();
        err_p1 = 1; halt_p1 = '1;
        tick(); quiet();
        n_cmp++; if (state !== 3'd4 || status !== 2'b11 || done !== 1'b1) begin
            n_fail++; $display("FAIL err_priority state=%0d sts=%b done=%b exp=4/11/1", state, status, done); end
        clear = 1; tick(); quiet();
        n_cmp++; if (state !== 3'd0 || status !== 2'b11) begin
            n_fail++; $display("FAIL err_ack state=%0d sts=%b exp=0/11", state, status); end
        start = 1; tick(); quiet();
        n_cmp++; if (state !== 3'd1 || {inst_count, cycle_count, halted_mask, status} !== '0) begin
            n_fail++; $display("FAIL restart_zero state=%0d inst=%h cyc=%0d mask=%b sts=%b", state, inst_count, cycle_count, halted_mask, status); end
    endtask

    task automatic test_reset_mid_run();
        retire_p1 = '1; repeat (3) tick();
        rst = 0; start = 1; tick();
        n_cmp++; if (state !== 3'd0 || {inst_count, cycle_count, halted_mask, status, done} !== '0) begin
            n_fail++; $display("FAIL midrun_reset state=%0d inst=%h cyc=%0d", state, inst_count, cycle_count); end
        tick();
        n_cmp++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_holds_start got=%0d exp=0", state); end
        rst = 1; quiet();
    endtask

    // Reference model: results of the run described as plain integers.
    int  m_state, m_status, m_cyc;
    int  m_cnt [NUM_CH];
    bit  m_mask[NUM_CH];

    function automatic void model_reset();
        m_state = 0; m_status = 0; m_cyc = 0;
        for (int i = 0; i < NUM_CH; i++) begin m_cnt[i] = 0; m_mask[i] = 0; end
    endfunction

    function automatic void model_step(bit r, bit s, bit c, bit [NUM_CH-1:0] ret, bit [NUM_CH-1:0] h, bit e);
        int  prev_cyc;
        bit  every;
        if (!r) begin model_reset(); return; end
        if (m_state == 0) begin
            if (s) begin model_reset(); m_state = 1; end
        end else if (m_state == 1) begin
            if (c) begin
                m_state = 0; m_status = 0;
            end else begin
                prev_cyc = m_cyc;
                m_cyc++;
                every = 1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ret[i] && !m_mask[i] && m_cnt[i] < CNT_MAX) m_cnt[i]++;
                    if (h[i]) m_mask[i] = 1;
                    if (!m_mask[i]) every = 0;
                end
                if (e)                           begin m_state = 4; m_status = 3; end
                else if (every)                  begin m_state = 2; m_status = 1; end
                else if (prev_cyc == TIMEOUT - 1) begin m_state = 3; m_status = 2; end
            end
        end else if (c) begin
            m_state = 0;
        end
    endfunction

    task automatic test_random();
        logic [NUM_CH*CNT_W-1:0] exp_inst;
        logic [NUM_CH-1:0]       exp_mask;
        rst = 0; quiet(); tick(); rst = 1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(199) != 0);
            start     = ($urandom_range(3) == 0);
            clear     = ($urandom_range(29) == 0);
            err_p1    = ($urandom_range(79) == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                retire_p1[i] = $urandom_range(1);
                halt_p1[i]   = ($urandom_range(11) == 0);
            end
            model_step(rst, start, clear, retire_p1, halt_p1, err_p1);
            tick();
            for (int i = 0; i < NUM_CH; i++) begin
                exp_inst[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
                exp_mask[i] = m_mask[i];
            end
            n_cmp++;
            if (state !== 3'(m_state) || status !== 2'(m_status) || cycle_count !== CYC_W'(m_cyc) ||
                inst_count !== exp_inst || halted_mask !== exp_mask || done !== (m_state >= 2)) begin
                n_fail++;
                $display("FAIL random_cycle%0d got st=%0d sts=%0d cyc=%0d inst=%h mask=%b done=%b exp st=%0d sts=%0d cyc=%0d inst=%h mask=%b",
                         n, state, status, cycle_count, inst_count, halted_mask, done,
                         m_state, m_status, m_cyc, exp_inst, exp_mask);
            end
        end
        quiet(); rst = 1;
    endtask

    initial begin
        quiet(); rst = 0;
        #2;
        test_reset();
        test_halt();
        test_timeout();
        test_partial_halt();
        test_saturate();
        test_simultaneous();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001 Parameter NUM_CH, default 1, number of independently retiring/halting channels (1..8).
REQ-002 Parameter CNT_W, default 16, width of each per-channel retired-instruction counter.
REQ-003 Parameter TIMEOUT, default 10000, cycles allowed in RUN before a timeout.
REQ-004 Derived localparam CYC_W = $clog2(TIMEOUT+1), width of the cycle counter.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 rst  input  1  synchronous, active-low reset; sampled on posedge clk only.
REQ-007 start  input  1  begin a run; honoured only in IDLE.
REQ-008 clear  input  1  abort a run or acknowledge a finished one; returns to IDLE.
REQ-009 retire_p1  input  NUM_CH  per-channel one-instruction-retired strobe.
REQ-010 halt_p1  input  NUM_CH  per-channel halt-instruction strobe.
REQ-011 err_p1  input  1  fatal error strobe, shared by all channels.
REQ-012 inst_count  output  NUM_CH*CNT_W  packed per-channel retired counts; channel 0 in the LSBs.
REQ-013 cycle_count  output  CYC_W  cycles spent in RUN.
REQ-014 halted_mask  output  NUM_CH  channels that have halted in the current run.
REQ-015 state  output  3  current FSM state encoding.
REQ-016 status  output  2  end cause: 00 none, 01 halt, 10 timeout, 11 error.
REQ-017 done  output  1  high in any terminal state.

Function
REQ-018 FSM states: IDLE, RUN, HALTED, TIMEOUT, ERROR; HALTED/TIMEOUT/ERROR are terminal.
REQ-019 All outputs are registered; each event is reflected on the posedge after it is sampled (latency 1).
REQ-020 IDLE with start=1: next state RUN; inst_count, cycle_count, halted_mask and status are all cleared to 0 at that same edge.
REQ-021 IDLE with start=0: all counters, halted_mask and status hold their values, so results of the previous run stay readable.
REQ-022 RUN: cycle_count increments by 1 every cycle.
REQ-023 RUN: inst_count[ch] increments by 1 when retire_p1[ch]=1 and halted_mask[ch]=0.
REQ-024 inst_count[ch] saturates at 2^CNT_W-1 and never wraps.
REQ-025 RUN: halt_p1[ch]=1 sets halted_mask[ch]; the bit stays set until the next start.
REQ-026 retire_p1[ch] and halt_p1[ch] high in the same cycle: the retire is counted; later retires on that channel are ignored.
REQ-027 RUN exits to HALTED with status 01 when (halted_mask | halt_p1) is all ones.
REQ-028 RUN exits to TIMEOUT with status 10 when cycle_count == TIMEOUT-1 is sampled; the increment at that edge makes cycle_count read TIMEOUT in the TIMEOUT state.
REQ-029 RUN exits to ERROR with status 11 when err_p1=1.
REQ-030 Priority among simultaneous RUN exits is clear > err_p1 > all-halted > timeout.
REQ-031 clear=1 in RUN: next state IDLE with status 00; counters and halted_mask hold their values.
REQ-032 Terminal states: counters and halted_mask are frozen; start, retire_p1, halt_p1 and err_p1 are ignored; clear=1 moves to IDLE with status retained.
REQ-033 clear and start both high in IDLE: start wins.
REQ-034 done = 1 exactly when state is HALTED, TIMEOUT or ERROR.

Reset
REQ-035 rst=0 at a posedge forces state IDLE and clears inst_count, cycle_count, halted_mask, status and done to 0.
REQ-036 Reset overrides every other input, including reset asserted in the middle of a run.
REQ-037 The first start is honoured on the first posedge at which rst=1.

Structure
REQ-038 The state enum (IDLE=0, RUN=1, HALTED=2, TIMEOUT=3, ERROR=4) and the status codes live in the shared package run_pkg.
REQ-039 The per-channel counter is a sub-module sat_counter (parameter W; inputs clk, rst, clr, inc; output q), instantiated NUM_CH times by a generate loop.

Verification
REQ-040 NUM_CH=1: start, 5 retires, then halt_p1 together with a retire -> HALTED, status 01, inst_count 6, done 1 cycle after the halt.
REQ-041 TIMEOUT=20, no halt -> TIMEOUT state after exactly 20 RUN cycles, cycle_count 20, status 10.
REQ-042 NUM_CH=2: ch0 halts at cycle 3 and keeps retiring, ch1 halts at cycle 7 -> HALTED at cycle 8; ch0 count excludes every retire after cycle 3.
REQ-043 CNT_W=3, 10 retires -> inst_count saturates at 7.
REQ-044 err_p1, halt_p1 (all channels) and the timeout in the same cycle -> ERROR, status 11; then clear -> IDLE with status 11 retained; then start -> all values zeroed.
REQ-045 rst=0 mid-RUN with counts nonzero -> next cycle IDLE and all outputs 0; start is ignored while rst=0.
